// File: rtl/ysyx_25010008_mem_arbiter_if.sv
// Requester-side and memory-side signals of the fetch/LSU memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface ysyx_25010008_mem_arbiter_if #(
    parameter int unsigned N = 2
) ();
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [32*N-1:0] addr;
    logic [32*N-1:0] wdata;
    logic [4*N-1:0]  wmask;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            mem_req;
    logic            mem_ready;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wmask;
    logic            mem_rvalid;
    logic [31:0]     mem_rdata;
    logic [1:0]      mem_resp;

    modport slave (
        input  req, we, addr, wdata, wmask, mem_ready, mem_rvalid, mem_rdata, mem_resp,
        output gnt, rsp_valid, rsp_rdata, rsp_resp,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output req, we, addr, wdata, wmask, mem_ready, mem_rvalid, mem_rdata, mem_resp,
        input  gnt, rsp_valid, rsp_rdata, rsp_resp,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_25010008_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (0) and load/store (1).
// One transaction in flight; a response timeout turns a hung memory into an error.
module ysyx_25010008_mem_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    ysyx_25010008_mem_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] OneHot0 = N'(1);

    typedef enum logic [1:0] {StIdle, StAddr, StResp, StDone} state_e;

    state_e          r_state,     w_state_next;
    logic [IdxW-1:0] r_owner,     w_owner_next;
    logic [IdxW-1:0] r_last,      w_last_next;
    logic [15:0]     r_cnt,       w_cnt_next;
    logic [N-1:0]    r_gnt,       w_gnt_next;
    logic [N-1:0]    r_rsp_valid, w_rsp_valid_next;
    logic [31:0]     r_rsp_rdata, w_rsp_rdata_next;
    logic [1:0]      r_rsp_resp,  w_rsp_resp_next;
    logic            r_mem_req,   w_mem_req_next;
    logic            r_mem_we,    w_mem_we_next;
    logic [31:0]     r_mem_addr,  w_mem_addr_next;
    logic [31:0]     r_mem_wdata, w_mem_wdata_next;
    logic [3:0]      r_mem_wmask, w_mem_wmask_next;
    logic            w_found;
    logic [IdxW-1:0] w_winner;
    logic [15:0]     w_cnt_inc;

    // First requester found scanning upward from the slot after the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            int unsigned idx;
            idx = 32'(r_last) + i;
            if (idx >= N) idx = idx - N;
            if (!w_found && bus.req[IdxW'(idx)]) begin
                w_found  = 1'b1;
                w_winner = IdxW'(idx);
            end
        end
    end

    assign w_cnt_inc = r_cnt + 16'd1;

    always_comb begin
        w_state_next     = r_state;
        w_owner_next     = r_owner;
        w_last_next      = r_last;
        w_cnt_next       = r_cnt;
        w_gnt_next       = '0;
        w_rsp_valid_next = '0;
        w_rsp_rdata_next = r_rsp_rdata;
        w_rsp_resp_next  = r_rsp_resp;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_mem_wmask_next = r_mem_wmask;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_owner_next     = w_winner;
                    w_mem_req_next   = 1'b1;
                    w_mem_we_next    = bus.we[w_winner];
                    w_mem_addr_next  = 32'(bus.addr >> (32 * 32'(w_winner)));
                    w_mem_wdata_next = 32'(bus.wdata >> (32 * 32'(w_winner)));
                    w_mem_wmask_next = 4'(bus.wmask >> (4 * 32'(w_winner)));
                    w_state_next     = StAddr;
                end
            end
            StAddr: begin
                if (bus.mem_ready) begin
                    w_mem_req_next = 1'b0;
                    w_gnt_next     = OneHot0 << r_owner;
                    w_cnt_next     = '0;
                    w_state_next   = StResp;
                end
            end
            StResp: begin
                // A real response wins over a timeout landing in the same cycle.
                if (bus.mem_rvalid) begin
                    w_rsp_rdata_next = bus.mem_rdata;
                    w_rsp_resp_next  = bus.mem_resp;
                    w_rsp_valid_next = OneHot0 << r_owner;
                    w_state_next     = StDone;
                end else if (w_cnt_inc == 16'(TIMEOUT)) begin
                    w_rsp_rdata_next = '0;
                    w_rsp_resp_next  = 2'b11;
                    w_rsp_valid_next = OneHot0 << r_owner;
                    w_state_next     = StDone;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            StDone: begin
                w_last_next  = r_owner;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_owner     <= '0;
            r_last      <= IdxW'(N - 1);
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
        end else begin
            r_state     <= w_state_next;
            r_owner     <= w_owner_next;
            r_last      <= w_last_next;
            r_cnt       <= w_cnt_next;
            r_gnt       <= w_gnt_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_rdata <= w_rsp_rdata_next;
            r_rsp_resp  <= w_rsp_resp_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_mem_wmask <= w_mem_wmask_next;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_resp  = r_rsp_resp;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wmask = r_mem_wmask;
endmodule

// File: tb/tb_ysyx_25010008_mem_arbiter.sv
// Bench for the memory arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ysyx_25010008_mem_arbiter;
    localparam int unsigned N       = 2;
    localparam int unsigned TIMEOUT = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ysyx_25010008_mem_arbiter_if #(.N(N)) bus ();

    ysyx_25010008_mem_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Memory responder configuration (delay -1 means never respond).
    int          cfg_ready_delay = 0;
    int          cfg_rsp_delay   = 0;
    logic [31:0] cfg_rdata       = '0;
    logic [1:0]  cfg_rresp       = '0;
    bit          stray           = 1'b0;

    initial begin : responder
        int a_wait, r_wait;
        bit pending;
        a_wait = 0; r_wait = 0; pending = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_resp = '0;
        while (1'b1) begin
            @(posedge clock);
            #2;
            bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_resp = '0;
            if (reset) begin
                pending = 1'b0; a_wait = 0; stray = 1'b0;
                continue;
            end
            if (bus.mem_req) begin
                if (a_wait >= cfg_ready_delay) bus.mem_ready = 1'b1;
                else a_wait++;
            end else a_wait = 0;
            if (bus.gnt != '0) begin pending = 1'b1; r_wait = 0; end
            if (pending && cfg_rsp_delay >= 0) begin
                if (r_wait >= cfg_rsp_delay) begin
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = cfg_rdata; bus.mem_resp = cfg_rresp;
                    pending = 1'b0;
                end else r_wait++;
            end
            if (stray) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0; bus.mem_resp = 2'b01;
                stray = 1'b0;
            end
        end
    end

    // Transaction-level model: expected output values, updated per clock edge.
    logic [N-1:0] exp_gnt = '0, exp_rsp_valid = '0;
    logic         exp_mem_req = 1'b0, exp_mem_we = 1'b0;
    logic [31:0]  exp_mem_addr = '0, exp_mem_wdata = '0, exp_rsp_rdata = '0;
    logic [3:0]   exp_mem_wmask = '0;
    logic [1:0]   exp_rsp_resp = '0;
    int unsigned  m_last = N - 1;

    function automatic bit req_bit(input int unsigned c);
        return ((32'(bus.req) >> c) & 32'd1) != 32'd0;
    endfunction

    task automatic model_tick(output bit hit);
        @(posedge clock or posedge reset);
        hit = reset;
        if (reset) begin
            exp_gnt = '0; exp_rsp_valid = '0; exp_mem_req = 1'b0; exp_mem_we = 1'b0;
            exp_mem_addr = '0; exp_mem_wdata = '0; exp_mem_wmask = '0;
            exp_rsp_rdata = '0; exp_rsp_resp = '0; m_last = N - 1;
        end
    endtask

    initial begin : model
        bit hit, abort;
        int unsigned owner, waited;
        while (1'b1) begin
            model_tick(hit);
            if (hit || bus.req == '0) continue;
            owner = N;
            for (int unsigned i = 1; i <= N; i++) begin
                int unsigned c;
                c = (m_last + i) % N;
                if (owner == N && req_bit(c)) owner = c;
            end
            exp_mem_req   = 1'b1;
            exp_mem_we    = 1'((32'(bus.we)) >> owner);
            exp_mem_addr  = 32'(bus.addr >> (32 * owner));
            exp_mem_wdata = 32'(bus.wdata >> (32 * owner));
            exp_mem_wmask = 4'(bus.wmask >> (4 * owner));
            abort = 1'b0;
            while (1'b1) begin
                model_tick(hit);
                if (hit) begin abort = 1'b1; break; end
                if (bus.mem_ready) break;
            end
            if (abort) continue;
            exp_mem_req = 1'b0;
            exp_gnt     = N'(32'd1 << owner);
            waited      = 0;
            while (1'b1) begin
                model_tick(hit);
                if (hit) begin abort = 1'b1; break; end
                exp_gnt = '0;
                waited++;
                if (bus.mem_rvalid) begin
                    exp_rsp_rdata = bus.mem_rdata; exp_rsp_resp = bus.mem_resp;
                    exp_rsp_valid = N'(32'd1 << owner);
                    break;
                end
                if (waited == TIMEOUT) begin
                    exp_rsp_rdata = '0; exp_rsp_resp = 2'b11;
                    exp_rsp_valid = N'(32'd1 << owner);
                    break;
                end
            end
            if (abort) continue;
            model_tick(hit);
            if (hit) continue;
            exp_rsp_valid = '0;
            m_last = owner;
        end
    end

    always @(negedge clock) begin : compare
        check("gnt",       32'(bus.gnt),       32'(exp_gnt));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp_valid));
        check("rsp_rdata", bus.rsp_rdata,      exp_rsp_rdata);
        check("rsp_resp",  32'(bus.rsp_resp),  32'(exp_rsp_resp));
        check("mem_req",   32'(bus.mem_req),   32'(exp_mem_req));
        check("mem_we",    32'(bus.mem_we),    32'(exp_mem_we));
        check("mem_addr",  bus.mem_addr,       exp_mem_addr);
        check("mem_wdata", bus.mem_wdata,      exp_mem_wdata);
        check("mem_wmask", 32'(bus.mem_wmask), 32'(exp_mem_wmask));
    end

    initial begin : stim
        int ngr;
        bit [3:0] order;
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.wmask = '0;
        #1 reset = 1'b1;
        step(3);
        check("reset mem_req", 32'(bus.mem_req), 32'h0);
        check("reset gnt", 32'(bus.gnt), 32'h0);
        check("reset mem_addr", bus.mem_addr, 32'h0);
        reset = 1'b0;

        // Both requesting from reset: grants alternate 0,1,0,1.
        bus.addr = {32'h0000_2000, 32'h0000_1000};
        cfg_rdata = 32'h1111_0000;
        bus.req = 2'b11;
        ngr = 0; order = '0;
        for (int c = 0; c < 40 && ngr < 4; c++) begin
            step(1);
            if (bus.gnt != '0) begin
                order = {order[2:0], bus.gnt[1]};
                ngr++;
                if (ngr == 4) bus.req = '0;
            end
        end
        check("rr grant count", 32'(ngr), 32'd4);
        check("rr grant order", 32'(order), 32'h5);
        step(4);

        // Single fetch read, minimum latency.
        bus.addr = {32'h0, 32'h2000_0000};
        cfg_rdata = 32'h0000_0413; cfg_rresp = 2'b00;
        bus.req = 2'b01;
        step(1);
        check("fetch mem_req", 32'(bus.mem_req), 32'h1);
        check("fetch mem_addr", bus.mem_addr, 32'h2000_0000);
        step(1);
        check("fetch gnt", 32'(bus.gnt), 32'h1);
        check("fetch early rsp", 32'(bus.rsp_valid), 32'h0);
        bus.req = '0;
        step(1);
        check("fetch rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("fetch rsp_rdata", bus.rsp_rdata, 32'h0000_0413);
        check("fetch rsp_resp", 32'(bus.rsp_resp), 32'h0);
        step(3);

        // LSU write with 5 stalled address cycles.
        cfg_ready_delay = 5; cfg_rsp_delay = 1; cfg_rdata = '0; cfg_rresp = 2'b10;
        bus.we = 2'b10; bus.addr = {32'h8000_0010, 32'h0};
        bus.wdata = {32'hDEAD_BEEF, 32'h0}; bus.wmask = {4'hF, 4'h0};
        bus.req = 2'b10;
        step(1);
        check("lsu mem_we", 32'(bus.mem_we), 32'h1);
        check("lsu mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("lsu mem_wmask", 32'(bus.mem_wmask), 32'hF);
        step(5);
        check("lsu stalled gnt", 32'(bus.gnt), 32'h0);
        check("lsu stalled mem_addr", bus.mem_addr, 32'h8000_0010);
        step(1);
        check("lsu gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0; bus.we = '0;
        step(1);
        check("lsu early rsp", 32'(bus.rsp_valid), 32'h0);
        step(1);
        check("lsu rsp_valid", 32'(bus.rsp_valid), 32'h2);
        check("lsu rsp_resp", 32'(bus.rsp_resp), 32'h2);
        step(3);

        // Timeout after 4 response cycles, then stray responses ignored.
        cfg_ready_delay = 0; cfg_rsp_delay = -1;
        bus.addr = {32'h0, 32'h0000_0100};
        bus.req = 2'b01;
        step(2);
        check("to gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        step(3);
        check("to not yet", 32'(bus.rsp_valid), 32'h0);
        step(1);
        check("to rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("to rsp_resp", 32'(bus.rsp_resp), 32'h3);
        check("to rsp_rdata", bus.rsp_rdata, 32'h0);
        stray = 1'b1;
        step(1);
        check("stray in done", 32'(bus.rsp_valid), 32'h0);
        stray = 1'b1;
        step(2);
        check("stray in idle", 32'(bus.rsp_valid), 32'h0);
        check("stray rdata", bus.rsp_rdata, 32'h0);
        step(2);

        // Async reset while gnt is high.
        bus.addr = {32'h0, 32'h0000_5000};
        bus.req = 2'b01;
        step(2);
        check("pre-reset gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        #2 reset = 1'b1;
        #1;
        check("async gnt", 32'(bus.gnt), 32'h0);
        check("async mem_addr", bus.mem_addr, 32'h0);
        check("async rsp_resp", 32'(bus.rsp_resp), 32'h3 & 32'h0);
        step(2);
        reset = 1'b0;

        // After reset requester 0 wins; requester 1 payload change is isolated.
        cfg_ready_delay = 2; cfg_rsp_delay = 1; cfg_rdata = 32'hCAFE_0000; cfg_rresp = 2'b00;
        bus.addr = {32'h0000_2000, 32'h0000_1000};
        bus.req = 2'b11;
        step(1);
        check("iso first addr", bus.mem_addr, 32'h0000_1000);
        bus.addr[63:32] = 32'h0000_3000;
        step(2);
        check("iso held addr", bus.mem_addr, 32'h0000_1000);
        step(1);
        check("post-reset gnt", 32'(bus.gnt), 32'h1);
        bus.req = 2'b10;
        step(2);
        check("iso rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("iso rsp_rdata", bus.rsp_rdata, 32'hCAFE_0000);
        check("iso done addr", bus.mem_addr, 32'h0000_1000);
        step(2);
        check("iso second addr", bus.mem_addr, 32'h0000_3000);
        step(3);
        check("iso second gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        step(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
